tt_sweep: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 16 +
 rtl/tt_hold_timer.sv | 32 +++
 rtl/tt_sweep.sv | 124 ++++++++++++
 tb/tb_tt_sweep.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_sweep_pkg;

  localparam int TT_N_IN       = 4;   // inputs of the function under test
  localparam int TT_N_MINTERMS = 16;  // 2**TT_N_IN
  localparam int TT_HOLD_W     = 16;  // hold counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } tt_state_t;

endpackage

// File: rtl/tt_hold_timer.sv
// Hold timer: counts clocks a vector is held, flags the final hold cycle.
// Latency: last is combinational from the count; count updates every enabled clock.
// Backpressure: none; clr wins over en, count wraps to 0 after reaching limit.
//
// Ports: clk/rst (async active-high), clr (force count to 0), en (advance),
//        limit (terminal count), last (count == limit).
module tt_hold_timer
  import tt_sweep_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TT_HOLD_W-1:0] limit,
  output logic                 last
);

  logic [TT_HOLD_W-1:0] cnt;

  assign last = (cnt == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper: drives minterms 0..15 on a,b,c,d, holds each HOLD_CYCLES clocks, captures f.
// Latency: done pulses 16*HOLD_CYCLES clocks after the accepted start; min start-to-start 16*H+2.
// Backpressure: none; start is only sampled in IDLE and ignored while sweeping.
//
// Ports: clk, rst (async active-high), start, f (function output, combinational
//        from a..d), a..d / idx (current minterm, a is MSB), busy, done (1-cycle),
//        tt (captured truth table, tt[i] = f at minterm i),
//        mismatch (tt != EXPECTED_TT at done; only with TT_SWEEP_CHECK_EN).
// Optional feature: define TT_SWEEP_CHECK_EN to add the golden-table compare.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int                        HOLD_CYCLES = 20,
  parameter logic [TT_N_MINTERMS-1:0]  EXPECTED_TT = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     f,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     d,
  output logic [TT_N_IN-1:0]       idx,
  output logic                     busy,
  output logic                     done,
  output logic [TT_N_MINTERMS-1:0] tt
`ifdef TT_SWEEP_CHECK_EN
  ,
  output logic                     mismatch
`endif
);

  localparam logic [TT_HOLD_W-1:0] HOLD_LIMIT = TT_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TT_N_IN-1:0]   IDX_LAST   = TT_N_IN'(TT_N_MINTERMS - 1);

  tt_state_t                  state, state_d;
  logic [TT_N_IN-1:0]         idx_q;
  logic [TT_N_MINTERMS-1:0]   tt_q;
  logic [TT_N_MINTERMS-1:0]   tt_cap;
  logic                       hold_last;
  logic                       sample;
  logic                       last_vec;
  logic                       accept;

  // Counter is held at 0 outside DRIVE so every sweep starts with a full hold.
  tt_hold_timer u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != DRIVE),
    .en    (state == DRIVE),
    .limit (HOLD_LIMIT),
    .last  (hold_last)
  );

  assign accept   = (state == IDLE) && start;
  assign sample   = (state == DRIVE) && hold_last;
  assign last_vec = (idx_q == IDX_LAST);

  // Truth table including the bit being captured this cycle; used both for
  // the capture itself and for the end-of-sweep compare.
  always_comb begin
    tt_cap        = tt_q;
    tt_cap[idx_q] = f;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample && last_vec) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // idx returns to 0 when leaving DRIVE, so FIN and IDLE drive minterm 0000.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      tt_q  <= '0;
    end else if (accept) begin
      idx_q <= '0;
      tt_q  <= '0;
    end else if (sample) begin
      tt_q  <= tt_cap;
      idx_q <= last_vec ? '0 : idx_q + 1'b1;
    end
  end

`ifdef TT_SWEEP_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (accept) begin
      mismatch_q <= 1'b0;
    end else if (sample && last_vec) begin
      mismatch_q <= (tt_cap != EXPECTED_TT);
    end
  end

  assign mismatch = mismatch_q;
`else
  // Golden table has no consumer without the compare; keep it referenced.
  localparam logic [TT_N_MINTERMS-1:0] expected_tt_unused = EXPECTED_TT;
`endif

  assign {a, b, c, d} = idx_q;
  assign idx          = idx_q;
  assign busy         = (state == DRIVE);
  assign done         = (state == FIN);
  assign tt           = tt_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: three instances (H = 20, 1, 2) share clock and reset.
// Functions under test are defined behaviourally; expected tables and timing
// come from the sweep rules (vector i held cycles i*H..(i+1)*H-1, done at 16*H).
module tb_tt_sweep;

  localparam int HV [3] = '{20, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [2:0]  f_v, a_v, b_v, c_v, d_v, busy_v, done_v;
  logic [3:0]  idx_v [3];
  logic [15:0] tt_v  [3];
  logic [2:0]  fsel  [3];
  logic [15:0] rtab  [3];
`ifdef TT_SWEEP_CHECK_EN
  logic [2:0]  mm_v;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // sel: 0 xor, 1 and, 2 stuck-at-0, 3 or, other: lookup in a random table
  function automatic logic fn(input logic [2:0] sel, input logic [3:0] m,
                              input logic [15:0] rt);
    case (sel)
      3'd0:    return m[3] ^ m[2] ^ m[1] ^ m[0];
      3'd1:    return m[3] & m[2] & m[1] & m[0];
      3'd2:    return 1'b0;
      3'd3:    return m[3] | m[2] | m[1] | m[0];
      default: return rt[m];
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign f_v[g] = fn(fsel[g], {a_v[g], b_v[g], c_v[g], d_v[g]}, rtab[g]);
    tt_sweep #(
      .HOLD_CYCLES (HV[g]),
      .EXPECTED_TT (16'h6996)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .f     (f_v[g]),
      .a     (a_v[g]),
      .b     (b_v[g]),
      .c     (c_v[g]),
      .d     (d_v[g]),
      .idx   (idx_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .tt    (tt_v[g])
`ifdef TT_SWEEP_CHECK_EN
      ,
      .mismatch (mm_v[g])
`endif
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input int g, input string name);
    chk({name, "_vec"}, {28'd0, a_v[g], b_v[g], c_v[g], d_v[g]}, 32'd0);
    chk({name, "_ctl"}, {26'd0, idx_v[g], busy_v[g], done_v[g]}, 32'd0);
    chk({name, "_tt"},  {16'd0, tt_v[g]}, 32'd0);
`ifdef TT_SWEEP_CHECK_EN
    chk({name, "_mm"},  {31'd0, mm_v[g]}, 32'd0);
`endif
  endtask

  // Run one sweep on instance g; t counts cycles after the start-sampling edge.
  task automatic sweep(input int g, input logic [2:0] sel, input logic [15:0] exp_tt,
                       input int repulse_t);
    int  h;
    bit  ok;
    logic [3:0] ev;
    h  = HV[g];
    ok = 1'b1;
    @(negedge clk);
    fsel[g]    = sel;
    start_v[g] = 1'b1;
    for (int t = 0; t <= 16 * h + 1; t++) begin
      @(negedge clk);
      if (t == 0) start_v[g] = 1'b0;
      if (t == repulse_t) start_v[g] = 1'b1;
      if (t == repulse_t + 1) start_v[g] = 1'b0;
      if (t < 16 * h) begin
        ev = 4'(t / h);
        if ({a_v[g], b_v[g], c_v[g], d_v[g]} !== ev || idx_v[g] !== ev ||
            busy_v[g] !== 1'b1 || done_v[g] !== 1'b0)
          ok = 1'b0;
        if (t == 0) begin
          chk("tt_cleared_on_start", {16'd0, tt_v[g]}, 32'd0);
`ifdef TT_SWEEP_CHECK_EN
          chk("mm_cleared_on_start", {31'd0, mm_v[g]}, 32'd0);
`endif
        end
      end else if (t == 16 * h) begin
        chk("done_at_16h", {31'd0, done_v[g]}, 32'd1);
        chk("busy_at_fin", {31'd0, busy_v[g]}, 32'd0);
        chk("vec_at_fin", {28'd0, a_v[g], b_v[g], c_v[g], d_v[g]}, 32'd0);
        chk("tt_final", {16'd0, tt_v[g]}, {16'd0, exp_tt});
`ifdef TT_SWEEP_CHECK_EN
        chk("mismatch", {31'd0, mm_v[g]}, {31'd0, (exp_tt != 16'h6996)});
`endif
      end else begin
        chk("done_one_cycle", {30'd0, done_v[g], busy_v[g]}, 32'd0);
        chk("tt_held", {16'd0, tt_v[g]}, {16'd0, exp_tt});
      end
    end
    chk("hold_seq", {31'd0, ok}, 32'd1);
  endtask

  typedef struct {
    int          inst;
    logic [2:0]  sel;
    logic [15:0] exp_tt;
  } vec_t;

  vec_t vt [5];

  initial begin
    int pos [3];
    int nd;
    int g;

    for (int i = 0; i < 3; i++) begin
      fsel[i] = 3'd0;
      rtab[i] = 16'h0;
    end

    vt[0] = '{inst: 0, sel: 3'd0, exp_tt: 16'h6996};  // H=20 xor
    vt[1] = '{inst: 1, sel: 3'd1, exp_tt: 16'h8000};  // H=1 and
    vt[2] = '{inst: 0, sel: 3'd2, exp_tt: 16'h0000};  // stuck-at-0
    vt[3] = '{inst: 2, sel: 3'd3, exp_tt: 16'hFFFE};  // H=2 or
    vt[4] = '{inst: 1, sel: 3'd0, exp_tt: 16'h6996};  // H=1 xor

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_zero(i, "reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) sweep(vt[i].inst, vt[i].sel, vt[i].exp_tt, -1);

    // Second start pulse mid-sweep must not disturb timing or capture.
    sweep(0, 3'd0, 16'h6996, 50);

    // Randomized functions: the captured table must equal the function's table.
    for (int i = 0; i < 4; i++) begin
      g = int'($urandom_range(1, 2));
      rtab[g] = 16'($urandom);
      sweep(g, 3'd4, rtab[g], -1);
    end

    // Reset at cycle 100 of an H=20 sweep.
    @(negedge clk);
    fsel[0]    = 3'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("tt_partial", {16'd0, tt_v[0]}, 32'h0016);
    chk("idx_partial", {28'd0, idx_v[0]}, 32'd5);
    rst = 1'b1;
    #1;
    chk_idle_zero(0, "midrst");
    @(negedge clk);
    chk_idle_zero(0, "midrst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero(0, "postrst");
    sweep(0, 3'd0, 16'h6996, -1);

    // Continuous start on H=2: done every 34 clocks, tt stable each time.
    @(negedge clk);
    rtab[2]    = 16'($urandom);
    fsel[2]    = 3'd4;
    start_v[2] = 1'b1;
    nd = 0;
    for (int t = 0; t < 120 && nd < 3; t++) begin
      @(negedge clk);
      if (done_v[2]) begin
        pos[nd] = t;
        chk("cont_tt", {16'd0, tt_v[2]}, {16'd0, rtab[2]});
        nd++;
      end
    end
    chk("cont_done_count", nd, 3);
    if (nd == 3) begin
      chk("cont_first_done", pos[0], 32);
      chk("cont_period1", pos[1] - pos[0], 34);
      chk("cont_period2", pos[2] - pos[1], 34);
    end
    start_v[2] = 1'b0;
    repeat (40) @(negedge clk);
    chk("cont_stop_idle", {30'd0, busy_v[2], done_v[2]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
